// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seven_seg_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b0;

    typedef enum logic {
        BLANK,
        ON
    } scan_state_t;

endpackage

// File: rtl/seven_segments_decoder.sv
// BCD to seven-segment decoder, active-high, gfedcba order (bit 0 = a).
// Codes 10..15 produce a dark digit.
module seven_segments_decoder
    import seven_seg_pkg::*;
(
    input  bcd_t digit,
    output seg_t segments
);

    // Pure lookup; no state
    always_comb begin
        segments = SEG_BLANK;
        case (digit)
            4'd0:    segments = 7'h3F;
            4'd1:    segments = 7'h06;
            4'd2:    segments = 7'h5B;
            4'd3:    segments = 7'h4F;
            4'd4:    segments = 7'h66;
            4'd5:    segments = 7'h6D;
            4'd6:    segments = 7'h7D;
            4'd7:    segments = 7'h07;
            4'd8:    segments = 7'h7F;
            4'd9:    segments = 7'h6F;
            default: segments = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// One shared decoder, blank interval at the start of every digit slot, and a
// shadow/display double buffer swapped only at frame boundaries (no tearing).
// Optional macro LEADING_ZERO_BLANK_EN: darkens leading zeros (digit 0 always
// shown); the mask is computed at buffer load and stored with the buffer.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [NUM_DIGITS-1:0]   an_n,
    output seg_t                    seg,
    output logic                    frame_done
);

    localparam int CNTW = $clog2(SLOT_CYCLES);
    localparam int IDXW = $clog2(NUM_DIGITS);
    localparam logic [CNTW-1:0] BLANK_LAST = CNTW'(BLANK_CYCLES - 1);
    localparam logic [CNTW-1:0] SLOT_LAST  = CNTW'(SLOT_CYCLES - 1);
    localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(NUM_DIGITS - 1);

    scan_state_t            state, state_nx;
    logic [CNTW-1:0]        cnt, cnt_nx;
    logic [IDXW-1:0]        idx, idx_nx;
    logic                   boundary;

    bcd_t [NUM_DIGITS-1:0]  disp_buf, shadow;
    logic                   pending;
    logic                   xfer, apply;

    bcd_t                   cur_digit;
    seg_t                   dec_seg;
    logic                   digit_blank;

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0]  lz_mask;

    // Digit k (k>0) is a leading zero when it and every digit above it are 0
    function automatic logic [NUM_DIGITS-1:0] lz_of(input bcd_t [NUM_DIGITS-1:0] d);
        logic [NUM_DIGITS-1:0] m;
        logic                  zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above & (d[k] == 4'd0);
            m[k]       = zero_above;
        end
        return m;
    endfunction
`endif

    // Scan state, slot counter and digit index registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
        end
    end

    // Next-state: blank/on sequencing per slot, digit advance, frame boundary
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        boundary = 1'b0;
        if (!en) begin
            state_nx = BLANK;
            cnt_nx   = '0;
            idx_nx   = '0;
        end else begin
            cnt_nx = (cnt == SLOT_LAST) ? '0 : cnt + 1'b1;
            case (state)
                BLANK: if (cnt == BLANK_LAST) state_nx = ON;
                ON: begin
                    if (cnt == SLOT_LAST) begin
                        state_nx = BLANK;
                        idx_nx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                        boundary = (idx == IDX_LAST);
                    end
                end
                default: state_nx = BLANK;
            endcase
        end
    end

    assign frame_done = boundary & ~rst;
    assign load_ready = ~pending;
    assign xfer       = load_valid & ~pending;
    // While scanning, swap only at the frame edge; while idle, swap at once
    assign apply      = pending & (boundary | ~en);

    // Shadow capture on handshake, display buffer swap at the frame boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow   <= '0;
            disp_buf <= '0;
            pending  <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            lz_mask  <= lz_of('0);
`endif
        end else if (xfer) begin
            shadow  <= load_data;
            pending <= 1'b1;
        end else if (apply) begin
            disp_buf <= shadow;
            pending  <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            lz_mask  <= lz_of(shadow);
`endif
        end
    end

    assign cur_digit = disp_buf[idx];

    seven_segments_decoder u_dec (
        .digit    (cur_digit),
        .segments (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    assign digit_blank = (cur_digit > 4'd9) | lz_mask[idx];
`else
    assign digit_blank = (cur_digit > 4'd9);
`endif

    // Registered drive; en gates it so disabling darkens on the next edge
    always_ff @(posedge clk) begin
        if (rst) begin
            an_n <= '1;
            seg  <= SEG_BLANK;
        end else if (en && state == ON) begin
            an_n <= ~(NUM_DIGITS'(1) << idx);
            seg  <= digit_blank ? SEG_BLANK : dec_seg;
        end else begin
            an_n <= '1;
            seg  <= SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl (NUM_DIGITS=4, SLOT=8, BLANK=2).
module tb_seven_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst, en, load_valid, load_ready, frame_done;
    logic [15:0] load_data;
    logic [3:0]  an_n;
    logic [6:0]  seg;

    int tests = 0;
    int errs  = 0;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS   (4),
        .SLOT_CYCLES  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .an_n       (an_n),
        .seg        (seg),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
        logic [3:0] dig;
        dig = v[4*d +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        if (d != 0 && (v >> (4*d)) == 16'h0) return 7'h00;
`endif
        return seg_of(dig);
    endfunction

    // Walks one frame from phase 'first'; outputs lag the scan state by 1 cycle
    task automatic check_frame(input logic [15:0] v, input int first);
        logic [3:0] ea;
        logic [6:0] es;
        int p, s, d;
        for (int i = first; i < 32; i++) begin
            chk($sformatf("frame_done v=%h i=%0d", v, i), frame_done, (i == 31));
            if (i >= 1) begin
                p = i - 1;
                s = p % 8;
                d = p / 8;
                if (s < 2) begin
                    ea = 4'hF;
                    es = 7'h00;
                end else begin
                    ea = ~(4'b0001 << d);
                    es = exp_seg(v, d);
                end
                chk($sformatf("an_n v=%h i=%0d", v, i), an_n, ea);
                chk($sformatf("seg v=%h i=%0d", v, i), seg, es);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load_valid = 1'b0; load_data = 16'h0;
        tick(); tick();
        chk("rst_an_n", an_n, 4'hF);
        chk("rst_seg", seg, 7'h00);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_ready", load_ready, 1'b1);

        // First load lands at the first boundary; frame 1 shows zeros
        rst = 1'b0; en = 1'b1; load_valid = 1'b1; load_data = 16'h1234;
        chk("ready_idle", load_ready, 1'b1);
        tick();
        load_valid = 1'b0;
        chk("ready_after_load", load_ready, 1'b0);
        check_frame(16'h0000, 1);
        check_frame(16'h1234, 0);

        // Handshake: 5678 accepted, 9999 held off until the boundary
        load_valid = 1'b1; load_data = 16'h5678;
        chk("ready_5678", load_ready, 1'b1);
        tick();
        load_data = 16'h9999;
        chk("ready_drop", load_ready, 1'b0);
        check_frame(16'h1234, 1);
        chk("ready_boundary", load_ready, 1'b1);
        tick();
        load_valid = 1'b0;
        chk("ready_9999", load_ready, 1'b0);
        check_frame(16'h5678, 1);
        check_frame(16'h9999, 0);

        // Non-decimal digit darkens its slot, anode still driven
        load_valid = 1'b1; load_data = 16'h00A3;
        tick();
        load_valid = 1'b0;
        check_frame(16'h9999, 1);
        check_frame(16'h00A3, 0);

        // Disable mid-slot at idx 2; pending frame applies while idle
        repeat (20) tick();
        chk("an_idx2", an_n, 4'b1011);
        en = 1'b0;
        tick();
        chk("en0_an_n", an_n, 4'hF);
        chk("en0_seg", seg, 7'h00);
        chk("en0_frame_done", frame_done, 1'b0);
        load_valid = 1'b1; load_data = 16'h0456;
        chk("en0_ready", load_ready, 1'b1);
        tick();
        load_valid = 1'b0;
        chk("en0_ready_drop", load_ready, 1'b0);
        tick();
        chk("en0_ready_back", load_ready, 1'b1);
        chk("en0_an_hold", an_n, 4'hF);
        en = 1'b1;
        check_frame(16'h0456, 0);

        // Leading-zero pattern
        load_valid = 1'b1; load_data = 16'h0040;
        tick();
        load_valid = 1'b0;
        check_frame(16'h0456, 1);
        check_frame(16'h0040, 0);

        // Reset with a pending frame: it must never reach the display
        load_valid = 1'b1; load_data = 16'h8888;
        tick();
        load_valid = 1'b0;
        chk("pend_ready", load_ready, 1'b0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_ready", load_ready, 1'b1);
        chk("rst2_an_n", an_n, 4'hF);
        chk("rst2_seg", seg, 7'h00);
        check_frame(16'h0000, 0);
        check_frame(16'h0000, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
